// File: rtl/pci_target_ctrl.sv
// PCI I/O-space target: claims I/O read/write cycles hitting BASE_ADDR and serves them from a small register file.
// Optional macro PCI_PARITY_EN adds even-parity generation on PAR; otherwise PAR stays hi-Z.
module pci_target_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int          MEM_DEPTH = 8,
  parameter int          ADDR_W    = 3
) (
  input  logic        clk,
  input  logic        rst,
  inout  wire  [31:0] AD,
  input  logic [3:0]  C_BE,
  input  logic        FRAME_n,
  input  logic        IRDY_n,
  output logic        DEVSEL_n,
  output logic        TRDY_n,
  output logic        STOP_n,
  output wire         PAR,
  output logic [7:0]  xfer_count
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_BUSY  = 3'd1;
  localparam logic [2:0] ST_CLAIM = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_DISC  = 3'd4;
  localparam logic [2:0] ST_TURN  = 3'd5;

  localparam logic [3:0] CMD_IO_RD = 4'b0010;
  localparam logic [3:0] CMD_IO_WR = 4'b0011;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MEM_DEPTH - 1);

  logic [2:0]        state_r, state_s;
  logic [ADDR_W-1:0] index_r, index_s;
  logic              is_read_r, is_read_s;
  logic [7:0]        xfer_count_r, xfer_count_s;
  logic [31:0]       mem_r [MEM_DEPTH];
  logic              devsel_n_r, trdy_n_r, stop_n_r, ad_oe_r;
  logic [31:0]       ad_out_r;
  logic              hit_s, claim_s, xfer_s;

  assign hit_s   = (AD[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
  assign claim_s = hit_s && ((C_BE == CMD_IO_RD) || (C_BE == CMD_IO_WR));
  assign xfer_s  = (state_r == ST_DATA) && !IRDY_n;

  // Next-state, index, command and transfer-count computation.
  always_comb begin
    state_s      = state_r;
    index_s      = index_r;
    is_read_s    = is_read_r;
    xfer_count_s = xfer_count_r;
    case (state_r)
      ST_IDLE: begin
        if (!FRAME_n) begin
          index_s   = AD[ADDR_W+1:2];
          is_read_s = (C_BE == CMD_IO_RD);
          if (claim_s) begin
            state_s      = ST_CLAIM;
            xfer_count_s = 8'd0;
          end else begin
            state_s = ST_BUSY;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (FRAME_n && IRDY_n) state_s = ST_IDLE;
        else                   state_s = ST_BUSY;
      end
      ST_CLAIM: state_s = ST_DATA;
      ST_DATA: begin
        if (xfer_s) begin
          xfer_count_s = (xfer_count_r == 8'hFF) ? xfer_count_r : xfer_count_r + 8'd1;
          // The last word always ends the burst: disconnect unless the initiator is already finishing.
          if (index_r == LAST_IDX) begin
            state_s = FRAME_n ? ST_TURN : ST_DISC;
          end else begin
            index_s = index_r + ADDR_W'(1);
            state_s = FRAME_n ? ST_TURN : ST_DATA;
          end
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_DISC: begin
        if (FRAME_n) state_s = ST_TURN;
        else         state_s = ST_DISC;
      end
      ST_TURN: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State, bookkeeping and registered bus outputs derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      index_r      <= '0;
      is_read_r    <= 1'b0;
      xfer_count_r <= 8'd0;
      devsel_n_r   <= 1'b1;
      trdy_n_r     <= 1'b1;
      stop_n_r     <= 1'b1;
      ad_oe_r      <= 1'b0;
      ad_out_r     <= 32'h0000_0000;
    end else begin
      state_r      <= state_s;
      index_r      <= index_s;
      is_read_r    <= is_read_s;
      xfer_count_r <= xfer_count_s;
      devsel_n_r   <= !((state_s == ST_CLAIM) || (state_s == ST_DATA) || (state_s == ST_DISC));
      trdy_n_r     <= !(state_s == ST_DATA);
      stop_n_r     <= !((state_s == ST_DISC) || ((state_s == ST_DATA) && (index_s == LAST_IDX)));
      ad_oe_r      <= (state_s == ST_DATA) && is_read_s;
      ad_out_r     <= mem_r[index_s];
    end
  end

  // Register file write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (xfer_s && !is_read_r) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (!C_BE[lane]) mem_r[index_r][8*lane +: 8] <= AD[8*lane +: 8];
      end
    end
  end

  assign AD         = ad_oe_r ? ad_out_r : {32{1'bz}};
  assign DEVSEL_n   = devsel_n_r;
  assign TRDY_n     = trdy_n_r;
  assign STOP_n     = stop_n_r;
  assign xfer_count = xfer_count_r;

`ifdef PCI_PARITY_EN
  function automatic logic even_parity(input logic [31:0] data, input logic [3:0] cbe);
    return ^{data, cbe};
  endfunction

  logic oe_d_r, par_r;

  // PAR lags AD by one clock and covers the previous cycle's AD and C_BE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oe_d_r <= 1'b0;
      par_r  <= 1'b0;
    end else begin
      oe_d_r <= ad_oe_r;
      par_r  <= even_parity(ad_out_r, C_BE);
    end
  end

  assign PAR = oe_d_r ? par_r : 1'bz;
`else
  assign PAR = 1'bz;
`endif

endmodule

// File: tb/tb_pci_target_ctrl.sv
// Randomized bench for pci_target_ctrl: a transaction-level model predicts every bus output each cycle.
// Undriven AD/PAR are pulled high so hi-Z is observable as all ones.
module tb_pci_target_ctrl;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  c_be;
  logic        frame_n, irdy_n;
  wire         devsel_n, trdy_n, stop_n;
  wire  [7:0]  xfer_count;
  tri1  [31:0] ad_bus;
  tri1         par_w;
  logic        tb_ad_oe;
  logic [31:0] tb_ad;

  assign ad_bus = tb_ad_oe ? tb_ad : {32{1'bz}};

  pci_target_ctrl dut (
    .clk(clk), .rst(rst), .AD(ad_bus), .C_BE(c_be), .FRAME_n(frame_n), .IRDY_n(irdy_n),
    .DEVSEL_n(devsel_n), .TRDY_n(trdy_n), .STOP_n(stop_n), .PAR(par_w), .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem_m [8];
  logic        exp_devsel, exp_trdy, exp_stop, exp_drv;
  logic [31:0] exp_ad;
  logic [7:0]  exp_cnt;
  bit          chk_en;
  logic        prev_drv;
  logic [31:0] prev_ad;
  logic [3:0]  prev_cbe;

  logic [31:0] dir_data[$];
  logic [3:0]  dir_be[$];
  int          dir_wait[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle_exp();
    exp_devsel = 1'b1; exp_trdy = 1'b1; exp_stop = 1'b1; exp_drv = 1'b0;
  endtask

  function automatic logic [31:0] next_data();
    if (dir_data.size() > 0) return dir_data.pop_front();
    return $urandom;
  endfunction

  function automatic logic [3:0] next_be();
    if (dir_be.size() > 0) return dir_be.pop_front();
    return 4'($urandom);
  endfunction

  function automatic int next_wait();
    if (dir_wait.size() > 0) return dir_wait.pop_front();
    return ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
  endfunction

  // Per-cycle comparison of every DUT output against the model's expectations.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("devsel_n", {31'd0, devsel_n}, {31'd0, exp_devsel});
      chk("trdy_n", {31'd0, trdy_n}, {31'd0, exp_trdy});
      chk("stop_n", {31'd0, stop_n}, {31'd0, exp_stop});
      chk("xfer_count", {24'd0, xfer_count}, {24'd0, exp_cnt});
      if (exp_drv) chk("ad_read_data", ad_bus, exp_ad);
      else if (!tb_ad_oe) chk("ad_hiz", ad_bus, 32'hFFFF_FFFF);
`ifdef PCI_PARITY_EN
      chk("par", {31'd0, par_w}, {31'd0, prev_drv ? ^{prev_ad, prev_cbe} : 1'b1});
`else
      chk("par_hiz", {31'd0, par_w}, 32'd1);
`endif
    end
    prev_drv = exp_drv;
    prev_ad  = exp_ad;
    prev_cbe = c_be;
  end

  // One initiator transaction; abort_at >= 0 asserts rst during that DATA cycle.
  task automatic run_txn(input logic [31:0] addr, input logic [3:0] cmd, input int nph, input int abort_at);
    bit claim, rd, disc, done;
    int idx, p, waits, n, cnt, k;
    logic [31:0] d;
    logic [3:0]  be;
    claim = (addr[31:5] == BASE[31:5]) && ((cmd == 4'b0010) || (cmd == 4'b0011));
    rd    = (cmd == 4'b0010);
    idx   = int'(addr[4:2]);
    frame_n = 1'b0; irdy_n = 1'b1; tb_ad_oe = 1'b1; tb_ad = addr; c_be = cmd;
    step();
    if (!claim) begin
      for (int i = 0; i < nph; i++) begin
        tb_ad = $urandom; c_be = 4'($urandom); irdy_n = 1'b0; frame_n = (i == nph - 1);
        step();
      end
      frame_n = 1'b1; irdy_n = 1'b1; tb_ad_oe = 1'b0;
      step();
      step();
      return;
    end
    exp_devsel = 1'b0; exp_trdy = 1'b1; exp_stop = 1'b1; exp_drv = 1'b0; exp_cnt = 8'd0;
    cnt = 0; p = 0; n = 0; disc = 1'b0; done = 1'b0;
    tb_ad_oe = !rd; tb_ad = $urandom; c_be = 4'h0; irdy_n = 1'b1; frame_n = 1'b0;
    waits = next_wait();
    step();
    while (!done) begin
      exp_devsel = 1'b0; exp_trdy = 1'b0; exp_stop = (idx == 7) ? 1'b0 : 1'b1;
      exp_drv = rd; exp_ad = mem_m[idx]; exp_cnt = 8'(cnt);
      if (n == abort_at) begin
        #2;
        rst = 1'b1;
        prev_drv = 1'b0;
        #1;
        chk("rst_devsel_n", {31'd0, devsel_n}, 32'd1);
        chk("rst_trdy_n", {31'd0, trdy_n}, 32'd1);
        chk("rst_stop_n", {31'd0, stop_n}, 32'd1);
        chk("rst_xfer_count", {24'd0, xfer_count}, 32'd0);
        chk("rst_ad_hiz", ad_bus, 32'hFFFF_FFFF);
        set_idle_exp(); exp_cnt = 8'd0;
        frame_n = 1'b1; irdy_n = 1'b1; tb_ad_oe = 1'b0;
        step();
        rst = 1'b0;
        step();
        return;
      end
      if (waits > 0) begin
        irdy_n = 1'b1; frame_n = 1'b0; c_be = 4'($urandom); waits--;
        be = 4'hF; d = 32'h0;
      end else begin
        irdy_n = 1'b0; frame_n = (p == nph - 1);
        d = next_data(); be = next_be(); c_be = be;
        if (!rd) tb_ad = d;
      end
      step();
      n++;
      if (!irdy_n) begin
        if (!rd) begin
          for (int l = 0; l < 4; l++) if (!be[l]) mem_m[idx][8*l +: 8] = d[8*l +: 8];
        end
        if (cnt < 255) cnt++;
        p++;
        if (idx == 7) begin
          disc = !frame_n;
          done = 1'b1;
        end else begin
          idx++;
          done = frame_n;
        end
        waits = next_wait();
      end
      if (n > 100) begin
        n_checks++; n_errors++;
        $display("FAIL data_phase_budget: got %0d cycles expected at most 100", n);
        done = 1'b1;
      end
    end
    tb_ad_oe = 1'b0;
    if (disc) begin
      exp_devsel = 1'b0; exp_trdy = 1'b1; exp_stop = 1'b0; exp_drv = 1'b0; exp_cnt = 8'(cnt);
      k = $urandom_range(0, 2);
      for (int i = 0; i <= k; i++) begin
        irdy_n = 1'b1; frame_n = (i == k);
        step();
      end
    end
    set_idle_exp(); exp_cnt = 8'(cnt);
    frame_n = 1'b1; irdy_n = 1'b1;
    step();
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]  rcmd;
    logic [31:0] raddr;
    rst = 1'b1; frame_n = 1'b1; irdy_n = 1'b1; c_be = 4'h0; tb_ad_oe = 1'b0; tb_ad = 32'h0;
    set_idle_exp(); exp_ad = 32'h0; exp_cnt = 8'd0; prev_drv = 1'b0; chk_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    step();

    // Fill the whole register file so every later read is predictable.
    for (int i = 0; i < 8; i++) dir_be.push_back(4'h0);
    run_txn(BASE, 4'b0011, 8, -1);
    chk("fill_count", {24'd0, xfer_count}, 32'd8);

    // Single full-word write.
    dir_wait.push_back(0); dir_data.push_back(32'hDEAD_BEEF); dir_be.push_back(4'b0000);
    run_txn(32'h0000_1004, 4'b0011, 1, -1);
    chk("t1_model_mem1", mem_m[1], 32'hDEAD_BEEF);
    chk("t1_count", {24'd0, xfer_count}, 32'd1);

    // Byte-lane write touching only lane 0.
    dir_wait.push_back(0); dir_data.push_back(32'h0000_00AA); dir_be.push_back(4'b1110);
    run_txn(32'h0000_1004, 4'b0011, 1, -1);
    chk("t2_model_mem1", mem_m[1], 32'hDEAD_BEAA);

    // Two-phase read with one IRDY wait state on the first phase.
    dir_wait.push_back(1); dir_wait.push_back(0);
    run_txn(32'h0000_1004, 4'b0010, 2, -1);
    chk("t3_count", {24'd0, xfer_count}, 32'd2);

    // Miss: nothing claimed, count left from previous transaction.
    run_txn(32'h0000_2000, 4'b0011, 1, -1);
    chk("t4_count_kept", {24'd0, xfer_count}, 32'd2);

    // Burst starting at the last word disconnects after one transfer.
    dir_wait.push_back(0); dir_data.push_back(32'h1234_5678); dir_be.push_back(4'b0000);
    run_txn(32'h0000_101C, 4'b0011, 3, -1);
    chk("t5_model_mem7", mem_m[7], 32'h1234_5678);
    chk("t5_count", {24'd0, xfer_count}, 32'd1);

    // Reset in the middle of a read burst, then normal traffic again.
    run_txn(32'h0000_1000, 4'b0010, 6, 2);
    chk("t6_count_after_rst", {24'd0, xfer_count}, 32'd0);
    run_txn(32'h0000_1008, 4'b0011, 1, -1);
    run_txn(32'h0000_1000, 4'b0010, 8, -1);
    chk("t6_readback_count", {24'd0, xfer_count}, 32'd8);

    // Randomized mix of hits, misses, unclaimed commands, waits and disconnects.
    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 6))
        0, 1, 2: rcmd = 4'b0010;
        3, 4:    rcmd = 4'b0011;
        5:       rcmd = 4'b0110;
        default: rcmd = 4'b1011;
      endcase
      if ($urandom_range(0, 4) == 0) raddr = 32'h0000_1020 + ($urandom & 32'h0FFF_FFE0);
      else raddr = BASE | 32'($urandom_range(0, 31));
      run_txn(raddr, rcmd, $urandom_range(1, 5), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
